// File: rtl/izhikevich_update.sv
// izhikevich_update: Euler update of Izhikevich v/w state with saturating Q16.16 math, spike reset and spike counter
module izhikevich_update #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter logic [N-1:0] V_INIT = 32'hFFBF0000,
  parameter logic [N-1:0] W_INIT = 32'hFFF30000,
  parameter logic [N-1:0] V_PEAK = 32'h001E0000,
  parameter logic [N-1:0] C = 32'hFFBF0000,
  parameter logic [N-1:0] D = 32'h00080000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [N-1:0]     dv,
  input  logic [N-1:0]     dw,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     v,
  output logic [N-1:0]     w,
  output logic             out_valid,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count
);
  typedef enum logic [1:0] {IDLE, SUM, COMMIT} state_t;
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("fractional bits must lie inside the word");
  end
  state_t state, state_n;
  logic [N-1:0] v_sum, w_sum, w_spk;
  logic fire, accept;
  function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] s;
    s = a + b;
    return (a[N-1] == b[N-1] && s[N-1] != a[N-1]) ? {a[N-1], {(N-1){~a[N-1]}}} : s;
  endfunction
  always_comb begin
    in_ready = state == IDLE;
    accept = in_valid & in_ready & ~clear;
    state_n = clear ? IDLE :
              state == IDLE ? (accept ? SUM : IDLE) :
              state == SUM ? COMMIT : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst || clear) begin
      v <= V_INIT;
      w <= W_INIT;
      v_sum <= '0;
      w_sum <= '0;
      w_spk <= '0;
      fire <= 1'b0;
      out_valid <= 1'b0;
      spike <= 1'b0;
      spike_count <= '0;
    end else begin
      out_valid <= state == COMMIT;
      spike <= state == COMMIT && fire;
      if (accept) begin
        v_sum <= sat_add(v, dv);
        w_sum <= sat_add(w, dw);
      end
      if (state == SUM) begin
        fire <= $signed(v_sum) >= $signed(V_PEAK);
        w_spk <= sat_add(w_sum, D);
      end
      if (state == COMMIT) begin
        v <= fire ? C : v_sum;
        w <= fire ? w_spk : w_sum;
        if (fire && !(&spike_count)) spike_count <= spike_count + 1'b1;
      end
    end
endmodule
